// File: rtl/pulse_arbiter.sv
// pulse_arbiter
// Round-robin scheduler that latches single-cycle event pulses from several
// sources as pending requests and hands them, one at a time, to a single
// downstream consumer over a valid/ready handshake. A programmable idle gap
// follows every accepted grant, and pulses that arrive while their channel is
// still pending are recorded as sticky overflow flags.

module pulse_arbiter #(
  parameter int NUM_CHANNELS = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int INDEX_WIDTH  = $clog2(NUM_CHANNELS)
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic [NUM_CHANNELS-1:0] i_Req,
  input  logic                    i_Ready,
  input  logic                    i_Clear_Overflow,
  output logic                    o_Valid,
  output logic [INDEX_WIDTH-1:0]  o_Index,
  output logic [NUM_CHANNELS-1:0] o_Pending,
  output logic [NUM_CHANNELS-1:0] o_Overflow
);

  // The gap counter is loaded with GAP_CYCLES-1 and counts down to zero, so it
  // only needs enough bits to hold that value (at least one bit).
  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t                  r_State;
  logic [INDEX_WIDTH-1:0]  r_Ptr;
  logic [CNT_W-1:0]        r_Cnt;
  logic                    r_Valid;
  logic [INDEX_WIDTH-1:0]  r_Index;
  logic [NUM_CHANNELS-1:0] r_Pending;
  logic [NUM_CHANNELS-1:0] r_Overflow;

  logic                    w_Xfer;
  logic [NUM_CHANNELS-1:0] w_XferMask;
  logic [NUM_CHANNELS-1:0] w_UpperMask;
  logic [NUM_CHANNELS-1:0] w_Upper;
  logic [INDEX_WIDTH-1:0]  w_PickUpper;
  logic [INDEX_WIDTH-1:0]  w_PickAll;
  logic [INDEX_WIDTH-1:0]  w_Pick;
  logic [INDEX_WIDTH-1:0]  w_PtrNext;

  // A grant is only ever presented from the GRANT state, so valid & ready is
  // exactly the transfer condition; ready while idle or in the gap is ignored.
  assign w_Xfer     = r_Valid & i_Ready;
  assign w_XferMask = w_Xfer ? (NUM_CHANNELS'(1) << r_Index) : '0;

  // Round-robin search: first look at pending bits at or above the pointer;
  // if none, wrap around and take the lowest pending bit overall.
  assign w_UpperMask = ~((NUM_CHANNELS'(1) << r_Ptr) - NUM_CHANNELS'(1));
  assign w_Upper     = r_Pending & w_UpperMask;

  // Lowest-set-bit encoders for both the masked and unmasked pending vectors.
  always_comb begin
    w_PickUpper = '0;
    w_PickAll   = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (w_Upper[i]) begin
        w_PickUpper = INDEX_WIDTH'(i);
      end
      if (r_Pending[i]) begin
        w_PickAll = INDEX_WIDTH'(i);
      end
    end
  end

  assign w_Pick = (|w_Upper) ? w_PickUpper : w_PickAll;

  // After serving channel c the search restarts at c+1, wrapping at the top.
  assign w_PtrNext = (r_Index == INDEX_WIDTH'(NUM_CHANNELS - 1)) ?
                     '0 : (r_Index + INDEX_WIDTH'(1));

  // Grant state machine: picks a pending channel, holds the grant until the
  // consumer accepts it, then idles for the configured gap.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_State <= ST_IDLE;
      r_Ptr   <= '0;
      r_Cnt   <= '0;
      r_Valid <= 1'b0;
      r_Index <= '0;
    end else begin
      case (r_State)
        ST_IDLE: begin
          if (|r_Pending) begin
            r_Index <= w_Pick;
            r_Valid <= 1'b1;
            r_State <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (i_Ready) begin
            r_Valid <= 1'b0;
            r_Ptr   <= w_PtrNext;
            if (GAP_CYCLES == 0) begin
              r_State <= ST_IDLE;
            end else begin
              r_Cnt   <= GAP_LOAD;
              r_State <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (r_Cnt == '0) begin
            r_State <= ST_IDLE;
          end else begin
            r_Cnt <= r_Cnt - CNT_W'(1);
          end
        end
        default: begin
          r_State <= ST_IDLE;
          r_Valid <= 1'b0;
        end
      endcase
    end
  end

  // Pending latch and sticky overflow flags; a new pulse always wins over a
  // same-edge transfer or clear, and a channel that is transferring on this
  // edge cannot overflow.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_Pending  <= '0;
      r_Overflow <= '0;
    end else begin
      r_Pending  <= (r_Pending & ~w_XferMask) | i_Req;
      r_Overflow <= (i_Clear_Overflow ? '0 : r_Overflow) |
                    (i_Req & r_Pending & ~w_XferMask);
    end
  end

  assign o_Valid    = r_Valid;
  assign o_Index    = r_Index;
  assign o_Pending  = r_Pending;
  assign o_Overflow = r_Overflow;

endmodule

// File: tb/tb_pulse_arbiter.sv
// tb_pulse_arbiter
// Directed scenarios plus a randomized run, all checked against a reference
// model that tracks pending/overflow sets and the earliest cycle at which the
// next grant may be issued.

module tb_pulse_arbiter;

  localparam int N  = 4;
  localparam int G  = 2;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rstN;
  logic [N-1:0]  req;
  logic          ready;
  logic          clearOvf;
  logic          valid;
  logic [IW-1:0] index;
  logic [N-1:0]  pending;
  logic [N-1:0]  overflow;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [N-1:0] mPend;
  logic [N-1:0] mOvf;
  bit           mValid;
  int           mIndex;
  int           mPtr;
  int           edgeNo;
  int           earliest;

  pulse_arbiter #(
    .NUM_CHANNELS(N),
    .GAP_CYCLES  (G),
    .INDEX_WIDTH (IW)
  ) dut (
    .i_Clk           (clk),
    .i_Rst           (rstN),
    .i_Req           (req),
    .i_Ready         (ready),
    .i_Clear_Overflow(clearOvf),
    .o_Valid         (valid),
    .o_Index         (index),
    .o_Pending       (pending),
    .o_Overflow      (overflow)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Watchdog so the bench always terminates
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [N-1:0] r, input logic rdy, input logic clr);
    req      = r;
    ready    = rdy;
    clearOvf = clr;
  endtask

  task automatic modelReset();
    mPend    = '0;
    mOvf     = '0;
    mValid   = 0;
    mIndex   = 0;
    mPtr     = 0;
    edgeNo   = 0;
    earliest = 0;
  endtask

  // Advance one clock edge with the currently driven inputs and update the
  // model: at most one grant outstanding, and after a transfer at edge T the
  // next grant decision may happen no earlier than edge T+G+1.
  task automatic step();
    logic [N-1:0] nPend;
    logic [N-1:0] nOvf;
    bit           xfer;
    int           pick;
    xfer = mValid && ready;
    for (int c = 0; c < N; c++) begin
      bit hit;
      hit      = xfer && (mIndex == c);
      nPend[c] = req[c] || (mPend[c] && !hit);
      nOvf[c]  = (req[c] && mPend[c] && !hit) || (mOvf[c] && !clearOvf);
    end
    edgeNo++;
    if (xfer) begin
      mValid   = 0;
      mPtr     = (mIndex + 1) % N;
      earliest = edgeNo + G + 1;
    end else if (!mValid && edgeNo >= earliest && mPend != '0) begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        if (pick < 0 && mPend[(mPtr + k) % N]) pick = (mPtr + k) % N;
      end
      mValid = 1;
      mIndex = pick;
    end
    mPend = nPend;
    mOvf  = nOvf;
    @(posedge clk);
    #1;
  endtask

  // Hold reset across a couple of edges, then release it away from any edge.
  task automatic doReset();
    applyStimulus('0, 1'b0, 1'b0);
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    modelReset();
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_valid: got %b, required 0", valid);
    end
    checks++;
    if (index !== '0) begin
      failures++;
      $display("[TB] FAIL reset_index: got %0d, required 0", index);
    end
    checks++;
    if (pending !== '0) begin
      failures++;
      $display("[TB] FAIL reset_pending: got %b, required 0000", pending);
    end
    checks++;
    if (overflow !== '0) begin
      failures++;
      $display("[TB] FAIL reset_overflow: got %b, required 0000", overflow);
    end
  endtask

  task automatic test_single();
    int grants;
    doReset();
    applyStimulus(4'b0100, 1'b1, 1'b0);
    step();
    checks++;
    if (pending !== 4'b0100 || valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_pending: got pend=%b valid=%b, required pend=0100 valid=0", pending, valid);
    end
    applyStimulus('0, 1'b1, 1'b0);
    step();
    checks++;
    if (valid !== 1'b1 || index !== 2'd2) begin
      failures++;
      $display("[TB] FAIL single_grant: got valid=%b idx=%0d, required valid=1 idx=2", valid, index);
    end
    step();
    checks++;
    if (valid !== 1'b0 || pending !== '0) begin
      failures++;
      $display("[TB] FAIL single_drop: got valid=%b pend=%b, required valid=0 pend=0000", valid, pending);
    end
    grants = 0;
    repeat (8) begin
      step();
      if (valid) grants++;
    end
    checks++;
    if (grants != 0) begin
      failures++;
      $display("[TB] FAIL single_no_second: got %0d extra grants, required 0", grants);
    end
  endtask

  task automatic test_round_robin();
    int idxSeen[$];
    int edgeSeen[$];
    doReset();
    applyStimulus(4'b1111, 1'b1, 1'b0);
    step();
    applyStimulus('0, 1'b1, 1'b0);
    repeat (30) begin
      step();
      if (valid) begin
        idxSeen.push_back(int'(index));
        edgeSeen.push_back(edgeNo);
      end
    end
    checks++;
    if (idxSeen.size() != 4) begin
      failures++;
      $display("[TB] FAIL rr_count: got %0d grants, required 4", idxSeen.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (idxSeen[i] != i) begin
          failures++;
          $display("[TB] FAIL rr_order: grant %0d got idx=%0d, required %0d", i, idxSeen[i], i);
        end
        if (i > 0) begin
          checks++;
          if (edgeSeen[i] - edgeSeen[i-1] != G + 2) begin
            failures++;
            $display("[TB] FAIL rr_spacing: got %0d cycles, required %0d", edgeSeen[i] - edgeSeen[i-1], G + 2);
          end
        end
      end
    end
    checks++;
    if (pending !== '0) begin
      failures++;
      $display("[TB] FAIL rr_pending_after: got %b, required 0000", pending);
    end
  endtask

  task automatic test_backpressure();
    int waitCycles;
    doReset();
    applyStimulus(4'b0010, 1'b0, 1'b0);
    step();
    applyStimulus('0, 1'b0, 1'b0);
    waitCycles = 0;
    while (!valid && waitCycles < 10) begin
      step();
      waitCycles++;
    end
    for (int cyc = 0; cyc < 5; cyc++) begin
      checks++;
      if (valid !== 1'b1 || index !== 2'd1) begin
        failures++;
        $display("[TB] FAIL bp_hold: cycle %0d got valid=%b idx=%0d, required valid=1 idx=1", cyc, valid, index);
      end
      if (cyc < 4) begin
        applyStimulus((cyc == 1) ? 4'b1000 : 4'b0000, 1'b0, 1'b0);
        step();
      end
    end
    applyStimulus('0, 1'b1, 1'b0);
    step();
    checks++;
    if (valid !== 1'b0 || pending !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL bp_transfer: got valid=%b pend=%b, required valid=0 pend=1000", valid, pending);
    end
    waitCycles = 0;
    while (!valid && waitCycles < 10) begin
      step();
      waitCycles++;
    end
    checks++;
    if (valid !== 1'b1 || index !== 2'd3 || waitCycles != G + 1) begin
      failures++;
      $display("[TB] FAIL bp_next: got valid=%b idx=%0d after %0d cycles, required valid=1 idx=3 after %0d", valid, index, waitCycles, G + 1);
    end
  endtask

  task automatic test_overflow();
    int xfers;
    doReset();
    applyStimulus(4'b0001, 1'b0, 1'b0);
    step();
    applyStimulus('0, 1'b0, 1'b0);
    step();
    applyStimulus(4'b0001, 1'b0, 1'b0);
    step();
    checks++;
    if (overflow !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL ovf_set: got %b, required 0001", overflow);
    end
    applyStimulus('0, 1'b0, 1'b0);
    step();
    checks++;
    if (overflow !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL ovf_sticky: got %b, required 0001", overflow);
    end
    applyStimulus('0, 1'b0, 1'b1);
    step();
    checks++;
    if (overflow !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL ovf_clear: got %b, required 0000", overflow);
    end
    applyStimulus(4'b0001, 1'b0, 1'b1);
    step();
    checks++;
    if (overflow !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL ovf_clear_vs_set: got %b, required 0001", overflow);
    end
    applyStimulus('0, 1'b1, 1'b0);
    xfers = 0;
    repeat (12) begin
      if (valid && ready && index == 2'd0) xfers++;
      step();
    end
    checks++;
    if (xfers != 1 || pending !== '0) begin
      failures++;
      $display("[TB] FAIL ovf_one_grant: got %0d grants pend=%b, required 1 grant pend=0000", xfers, pending);
    end
  endtask

  task automatic test_back_to_back();
    int waitCycles;
    doReset();
    applyStimulus(4'b0100, 1'b0, 1'b0);
    step();
    applyStimulus('0, 1'b0, 1'b0);
    step();
    checks++;
    if (valid !== 1'b1 || index !== 2'd2) begin
      failures++;
      $display("[TB] FAIL b2b_first: got valid=%b idx=%0d, required valid=1 idx=2", valid, index);
    end
    applyStimulus(4'b0100, 1'b1, 1'b0);
    step();
    checks++;
    if (pending[2] !== 1'b1 || overflow[2] !== 1'b0 || valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_set_wins: got pend2=%b ovf2=%b valid=%b, required 1 0 0", pending[2], overflow[2], valid);
    end
    applyStimulus('0, 1'b1, 1'b0);
    waitCycles = 0;
    while (!valid && waitCycles < 10) begin
      step();
      waitCycles++;
    end
    checks++;
    if (valid !== 1'b1 || index !== 2'd2) begin
      failures++;
      $display("[TB] FAIL b2b_second: got valid=%b idx=%0d, required valid=1 idx=2", valid, index);
    end
  endtask

  task automatic test_reset_mid_grant();
    int grants;
    doReset();
    applyStimulus(4'b0001, 1'b0, 1'b0);
    step();
    applyStimulus('0, 1'b0, 1'b0);
    step();
    applyStimulus(4'b0011, 1'b0, 1'b0);
    step();
    applyStimulus('0, 1'b0, 1'b0);
    checks++;
    if (valid !== 1'b1 || overflow !== 4'b0001 || pending !== 4'b0011) begin
      failures++;
      $display("[TB] FAIL mid_setup: got valid=%b ovf=%b pend=%b, required 1 0001 0011", valid, overflow, pending);
    end
    #2;
    rstN = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || index !== '0 || pending !== '0 || overflow !== '0) begin
      failures++;
      $display("[TB] FAIL mid_async_clear: got valid=%b idx=%0d pend=%b ovf=%b, required all 0", valid, index, pending, overflow);
    end
    @(posedge clk);
    #1;
    rstN = 1'b1;
    modelReset();
    grants = 0;
    repeat (10) begin
      step();
      if (valid) grants++;
    end
    checks++;
    if (grants != 0) begin
      failures++;
      $display("[TB] FAIL mid_no_grant: got %0d grant cycles, required 0", grants);
    end
  endtask

  task automatic test_random();
    doReset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      applyStimulus(N'($urandom_range(0, 15) & $urandom_range(0, 15)),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 15) == 0));
      step();
      checks++;
      if (valid !== mValid) begin
        failures++;
        $display("[TB] FAIL rand_valid: cycle %0d got %b, required %b", cyc, valid, mValid);
      end
      if (mValid) begin
        checks++;
        if (int'(index) != mIndex) begin
          failures++;
          $display("[TB] FAIL rand_index: cycle %0d got %0d, required %0d", cyc, index, mIndex);
        end
      end
      checks++;
      if (pending !== mPend) begin
        failures++;
        $display("[TB] FAIL rand_pending: cycle %0d got %b, required %b", cyc, pending, mPend);
      end
      checks++;
      if (overflow !== mOvf) begin
        failures++;
        $display("[TB] FAIL rand_overflow: cycle %0d got %b, required %b", cyc, overflow, mOvf);
      end
    end
  endtask

  // Scenario sequence
  initial begin
    rstN = 1'b0;
    applyStimulus('0, 1'b0, 1'b0);
    modelReset();
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_reset_mid_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
